// File: rtl/progmem_arbiter.sv
// progmem_arbiter: arbitrates one single-port program memory between the CPU fetch
// port and a loader/debug port, with a boot hold phase and loader starvation relief.
`default_nettype none

module progmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_release,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              run
);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD    = 2'd2
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  owner_t     owner;
  owner_t     owner_nxt;
  logic [3:0] starve;
  logic [3:0] starve_nxt;
  logic       starve_full;

  assign starve_full = (starve == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= HOLD;
      owner  <= OWN_NONE;
      starve <= 4'd0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      starve <= starve_nxt;
    end
  end

  // Grants are masked while reset is high so the memory never sees a write during reset.
  always_comb begin
    fetch_gnt  = 1'b0;
    ld_gnt     = 1'b0;
    state_nxt  = state;
    starve_nxt = starve;
    if (!reset) begin
      case (state)
        HOLD: begin
          ld_gnt     = ld_req;
          starve_nxt = 4'd0;
          if (boot_release) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (fetch_req && !(ld_req && starve_full)) begin
            fetch_gnt = 1'b1;
          end else begin
            ld_gnt = ld_req;
          end
          if (ld_req && !ld_gnt) begin
            starve_nxt = starve_full ? starve : starve + 4'd1;
          end else begin
            starve_nxt = 4'd0;
          end
        end
        default: begin
          state_nxt = HOLD;
        end
      endcase
    end
  end

  // Only reads earn a return slot; loader writes leave the owner tag empty.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (fetch_gnt) begin
      owner_nxt = OWN_FETCH;
    end else if (ld_gnt && !ld_we) begin
      owner_nxt = OWN_LD;
    end
  end

  assign mem_addr = ld_gnt ? ld_addr : fetch_addr;
  assign mem_din  = ld_gnt ? ld_wdata : '0;
  assign mem_we   = ld_gnt & ld_we;

  assign fetch_rvalid = (owner == OWN_FETCH);
  assign ld_rvalid    = (owner == OWN_LD);
  assign fetch_rdata  = mem_dout;
  assign ld_rdata     = mem_dout;
  assign run          = (state == RUN);

endmodule

`default_nettype wire

// File: tb/tb_progmem_arbiter.sv
// tb_progmem_arbiter: directed checks plus randomized traffic against a cycle-level
// behavioural model of the arbitration rules and the program memory contents.
`default_nettype none

module tb_progmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        boot_release;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [15:0] fetch_rdata;
  logic        ld_req;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [15:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [15:0] ld_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;
  logic        run;

  int total = 0;
  int bad   = 0;

  progmem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .boot_release(boot_release),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .ld_req(ld_req),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt),
    .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_we(mem_we),
    .mem_dout(mem_dout),
    .run(run)
  );

  always #5 clk = ~clk;

  // Program memory: 256 words, registered read, preloaded on its first clock.
  logic [15:0] env_mem [256];
  logic        mem_inited = 1'b0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 16'(16'hA000 + i);
      mem_inited <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_addr[7:0]] <= mem_din;
    end
    mem_dout <= env_mem[mem_addr[7:0]];
  end

  // Behavioural model state
  logic [15:0] m_mem [256];
  bit          m_run;
  int          m_starve;
  int          m_pend;       // 0 none, 1 fetch read, 2 loader read
  logic [15:0] m_pend_data;

  // Observations from the most recent cycle, for literal checks
  logic        obs_fgnt, obs_lgnt, obs_frv, obs_lrv, obs_we, obs_run;
  logic [15:0] obs_frd, obs_lrd, obs_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_starve = 0;
    m_pend   = 0;
  endtask

  task automatic cycle(input logic fr, input logic [15:0] fa, input logic lr, input logic lwe,
                       input logic [15:0] la, input logic [15:0] lwd, input logic br);
    logic        ef, el;
    logic [15:0] a;
    @(negedge clk);
    reset        = 1'b0;
    fetch_req    = fr;
    fetch_addr   = fa;
    ld_req       = lr;
    ld_we        = lwe;
    ld_addr      = la;
    ld_wdata     = lwd;
    boot_release = br;
    #2;
    ef = 1'b0;
    el = 1'b0;
    if (!m_run)                      el = lr;
    else if (!fr)                    el = lr;
    else if (lr && m_starve >= LIMIT) el = 1'b1;
    else                             ef = 1'b1;
    a = el ? la : fa;
    chk("fetch_gnt", fetch_gnt, ef);
    chk("ld_gnt", ld_gnt, el);
    chk("mem_addr", mem_addr, a);
    chk("mem_din", mem_din, el ? lwd : 16'h0);
    chk("mem_we", mem_we, el & lwe);
    chk("run", run, m_run);
    chk("fetch_rvalid", fetch_rvalid, m_pend == 1);
    chk("ld_rvalid", ld_rvalid, m_pend == 2);
    if (m_pend == 1) chk("fetch_rdata", fetch_rdata, m_pend_data);
    if (m_pend == 2) chk("ld_rdata", ld_rdata, m_pend_data);
    obs_fgnt = fetch_gnt; obs_lgnt = ld_gnt; obs_frv = fetch_rvalid; obs_lrv = ld_rvalid;
    obs_frd = fetch_rdata; obs_lrd = ld_rdata; obs_we = mem_we; obs_addr = mem_addr; obs_run = run;
    @(posedge clk);
    if (el && lwe) m_mem[a[7:0]] = lwd;
    m_pend      = ef ? 1 : ((el && !lwe) ? 2 : 0);
    m_pend_data = m_mem[a[7:0]];
    if (m_run) m_starve = (lr && !el) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
    if (br) m_run = 1'b1;
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  // Asserts reset mid-cycle with a loader write pending, to check asynchronous clearing.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    ld_req    = 1'b1;
    ld_we     = 1'b1;
    fetch_req = 1'b1;
    #2;
    chk("rst_run", run, 1'b0);
    chk("rst_fetch_rvalid", fetch_rvalid, 1'b0);
    chk("rst_ld_rvalid", ld_rvalid, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_ld_gnt", ld_gnt, 1'b0);
    chk("rst_fetch_gnt", fetch_gnt, 1'b0);
    model_reset();
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 16'(16'hA000 + i);
    model_reset();
    reset = 1'b1; boot_release = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h0;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0; ld_wdata = 16'h0;
    #2;
    chk("init_run", run, 1'b0);
    chk("init_mem_we", mem_we, 1'b0);
    chk("init_fetch_rvalid", fetch_rvalid, 1'b0);
    chk("init_ld_rvalid", ld_rvalid, 1'b0);

    // HOLD: loader write wins, fetch blocked
    cycle(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    chk("hold_fetch_gnt", obs_fgnt, 1'b0);
    chk("hold_ld_gnt", obs_lgnt, 1'b1);
    chk("hold_mem_we", obs_we, 1'b1);
    chk("hold_mem_addr", obs_addr, 16'h0010);
    // boot_release alongside a HOLD loader grant: grant completes, RUN next cycle
    cycle(1'b1, 16'h0005, 1'b1, 1'b1, 16'h0011, 16'h1234, 1'b1);
    chk("boot_ld_gnt", obs_lgnt, 1'b1);
    chk("boot_run_still_low", obs_run, 1'b0);
    cycle(1'b1, 16'h0003, 1'b1, 1'b0, 16'h0011, 16'h0, 1'b0);
    chk("run_fetch_prio", obs_fgnt, 1'b1);
    chk("run_high", obs_run, 1'b1);
    idle();

    // Loader read of the word written in HOLD
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    chk("ldrd_gnt", obs_lgnt, 1'b1);
    idle();
    chk("ldrd_rvalid", obs_lrv, 1'b1);
    chk("ldrd_data", obs_lrd, 16'hBEEF);
    chk("ldrd_no_frv", obs_frv, 1'b0);

    // Continuous contention: loader forced through every fifth cycle
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
      chk("starve_pattern", obs_lgnt, (i % 5) == 4);
    end
    idle();
    idle();

    // Back-to-back fetches return in address order
    cycle(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cycle(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("b2b_rv0", obs_frv, 1'b1);
    chk("b2b_d0", obs_frd, 16'hA000);
    cycle(1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("b2b_rv1", obs_frv, 1'b1);
    chk("b2b_d1", obs_frd, 16'hA001);
    idle();
    chk("b2b_rv2", obs_frv, 1'b1);
    chk("b2b_d2", obs_frd, 16'hA002);
    idle();
    chk("b2b_rv_end", obs_frv, 1'b0);

    // Write then read-after-write to the same address
    cycle(1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 16'h5A5A, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0);
    chk("raw_no_rvalid_for_write", obs_lrv, 1'b0);
    idle();
    chk("raw_data", obs_lrd, 16'h5A5A);

    // Reset the cycle after a fetch grant
    cycle(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    do_reset();
    cycle(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("postrst_frv", obs_frv, 1'b0);
    chk("postrst_fgnt", obs_fgnt, 1'b0);
    chk("postrst_run", obs_run, 1'b0);
    cycle(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    chk("postrst_boot_fgnt", obs_fgnt, 1'b0);
    cycle(1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("postrst_resume_fgnt", obs_fgnt, 1'b1);
    idle();
    chk("postrst_resume_data", obs_frd, 16'hA041);

    // Randomized traffic, occasional resets and boot releases
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom_range(0, 255)), 16'($urandom),
              ($urandom_range(0, 19) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/progmem_arbiter.md
PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, width of all address ports.
REQ-002 Parameter DATA_W, default 16, width of all data ports.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive loader denials before the loader is granted a forced cycle; legal range 1-15.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 boot_release  in  1  single-cycle pulse; moves the arbiter from HOLD to RUN.
REQ-007 fetch_req  in  1  CPU instruction-fetch read request.
REQ-008 fetch_addr  in  ADDR_W  fetch address.
REQ-009 fetch_gnt  out  1  fetch request accepted this cycle.
REQ-010 fetch_rvalid  out  1  fetch_rdata valid this cycle.
REQ-011 fetch_rdata  out  DATA_W  fetch read data.
REQ-012 ld_req  in  1  loader/debug access request.
REQ-013 ld_we  in  1  loader access is a write (1) or read (0).
REQ-014 ld_addr  in  ADDR_W  loader address.
REQ-015 ld_wdata  in  DATA_W  loader write data.
REQ-016 ld_gnt  out  1  loader request accepted this cycle.
REQ-017 ld_rvalid  out  1  ld_rdata valid this cycle; loader reads only.
REQ-018 ld_rdata  out  DATA_W  loader read data.
REQ-019 mem_addr  out  ADDR_W  program memory address.
REQ-020 mem_din  out  DATA_W  program memory write data.
REQ-021 mem_we  out  1  program memory write enable.
REQ-022 mem_dout  in  DATA_W  program memory registered read data; valid one cycle after address.
REQ-023 run  out  1  high in RUN state.

Function
REQ-024 States: HOLD (fetch blocked, loader only), RUN (shared); HOLD->RUN on boot_release; RUN is terminal until reset.
REQ-025 Grants combinational from current requests and registered state; at most one of fetch_gnt/ld_gnt high per cycle.
REQ-026 HOLD: ld_gnt = ld_req; fetch_gnt = 0.
REQ-027 RUN: fetch has priority; ld_gnt only when fetch_req = 0 or starve count = STARVE_LIMIT.
REQ-028 Starve counter: in RUN, increments when ld_req=1 and ld_gnt=0, clears when ld_gnt=1 or ld_req=0; saturates at STARVE_LIMIT.
REQ-029 Memory port driven by granted requester: mem_addr/mem_we/mem_din from it; mem_we = ld_gnt & ld_we; no grant -> mem_we = 0, mem_addr = fetch_addr, mem_din = 0.
REQ-030 Read latency 1: registered owner tag records read grant (fetch, loader-read, none); next cycle raises matching rvalid for one cycle, routes mem_dout to its rdata.
REQ-031 fetch_rdata and ld_rdata both carry mem_dout combinationally; only rvalid qualifies them.
REQ-032 Loader writes produce no rvalid; write in cycle N then read in N+1 to same address returns new data in N+2.
REQ-033 boot_release in the same cycle as a HOLD loader grant: that grant completes; RUN rules apply from the next cycle.
REQ-034 boot_release while in RUN: ignored.

Reset
REQ-035 reset asserted: state HOLD, starve counter 0, owner tag none, all rvalid 0, run 0, mem_we 0, within the same cycle (asynchronous).
REQ-036 reset mid-transaction: pending rvalid discarded; no rvalid after reset deasserts until a new grant.
REQ-037 Reset leaves memory contents untouched; grants resume the first cycle after reset deasserts.

Verification
REQ-038 HOLD: fetch_req=1, ld_req=1 ld_we=1 addr 0x010 data 0xBEEF -> fetch_gnt 0, ld_gnt 1, mem_we 1, mem_addr 0x010.
REQ-039 RUN after boot_release: ld read 0x010 with fetch_req=0 -> ld_gnt 1, next cycle ld_rvalid 1, ld_rdata 0xBEEF, fetch_rvalid 0.
REQ-040 RUN, fetch_req and ld_req held continuously, STARVE_LIMIT=4 -> fetch granted 4 cycles, ld_gnt on cycle 5, fetch regains cycle 6; pattern repeats.
REQ-041 RUN, back-to-back fetches 0x000,0x001,0x002 -> fetch_rvalid high three consecutive cycles from N+1, data in address order.
REQ-042 reset pulse the cycle after a fetch grant -> fetch_rvalid stays 0, run 0, state HOLD; fetch_gnt 0 until next boot_release.
